// File: rtl/ibex_wb_pkg.sv
// Shared types for the writeback arbiter: write-port entry, skid-buffer state
// and register-address helpers used by the arbiter and its forwarding comparators.
package ibex_wb_pkg;

  localparam int unsigned WbDataWidth = 32;

  typedef struct packed {
    logic                   valid;
    logic [4:0]             addr;
    logic [WbDataWidth-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  function automatic int unsigned addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

  // Addresses are masked to the active width before storage, so a full compare is exact.
  function automatic logic entry_hit(input wb_entry_t e, input logic [4:0] raddr);
    return e.valid && (e.addr == raddr) && (raddr != 5'd0);
  endfunction

endpackage

// File: rtl/ibex_wb_fwd_match.sv
// One read port's forwarding comparator: picks the youngest in-flight write
// (BUF, then OUT, then SHD) whose destination matches the read address.
module ibex_wb_fwd_match
  import ibex_wb_pkg::*;
(
  input  wb_entry_t              i_buf,
  input  wb_entry_t              i_out,
  input  wb_entry_t              i_shd,
  input  logic [4:0]             i_raddr,
  output logic                   o_valid,
  output logic [WbDataWidth-1:0] o_data
);

  // NOTE: both outputs get a default first so no path through the block infers a latch.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    if (entry_hit(i_buf, i_raddr)) begin
      o_valid = 1'b1;
      o_data  = i_buf.data;
    end else if (entry_hit(i_out, i_raddr)) begin
      o_valid = 1'b1;
      o_data  = i_out.data;
    end else if (entry_hit(i_shd, i_raddr)) begin
      o_valid = 1'b1;
      o_data  = i_shd.data;
    end
  end

endmodule

// File: rtl/ibex_wb_write_arbiter.sv
// Merges execute results and load responses onto the register file write port.
// Define IBEX_WB_FWD_EN to build the forwarding muxes and the shadow register.
module ibex_wb_write_arbiter
  import ibex_wb_pkg::*;
#(
  parameter int unsigned DataWidth         = WbDataWidth,
  parameter bit          RV32E             = 1'b0,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  input  logic                 ld_issue_i,
  input  logic [4:0]           ld_issue_waddr_i,
  input  logic                 dummy_instr_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_a_valid_o,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 hazard_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o
);

  localparam int unsigned AddrWidth = addr_width(RV32E);
  localparam logic [4:0]  AddrMask  = 5'((32'd1 << AddrWidth) - 32'd1);

  buf_state_e r_state, w_state_nxt;
  wb_entry_t  r_out, r_buf, w_out_nxt, w_buf_nxt;
  wb_entry_t  w_ex_entry, w_lsu_entry;
  logic       r_pl_valid;
  logic [4:0] r_pl_addr;
  logic       w_ex_keep, w_lsu_keep, w_keep_x0, w_pl_hit;
  logic [4:0] w_ra_a, w_ra_b;

  assign w_ex_entry  = '{valid: 1'b1, addr: ex_waddr_i & AddrMask, data: ex_wdata_i};
  assign w_lsu_entry = '{valid: 1'b1, addr: lsu_waddr_i & AddrMask, data: lsu_wdata_i};

  // x0 writes are dropped before they reach any state; EX still handshakes.
  assign w_keep_x0  = DummyInstructions && dummy_instr_i;
  assign w_ex_keep  = ex_valid_i && ((w_ex_entry.addr != 5'd0) || w_keep_x0);
  assign w_lsu_keep = lsu_valid_i && ((w_lsu_entry.addr != 5'd0) || w_keep_x0);

  assign ex_ready_o = (r_state == EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = '0;
    w_buf_nxt   = r_buf;
    unique case (r_state)
      EMPTY: begin
        if (w_lsu_keep) begin
          w_out_nxt = w_lsu_entry;
          if (w_ex_keep) begin
            w_buf_nxt   = w_ex_entry;
            w_state_nxt = FULL;
          end
        end else if (w_ex_keep) begin
          w_out_nxt = w_ex_entry;
        end
      end
      FULL: begin
        if (w_lsu_keep) begin
          w_out_nxt = w_lsu_entry;
        end else begin
          w_out_nxt       = r_buf;
          w_buf_nxt.valid = 1'b0;
          w_state_nxt     = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= EMPTY;
      r_out      <= '0;
      r_buf      <= '0;
      r_pl_valid <= 1'b0;
      r_pl_addr  <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_buf   <= w_buf_nxt;
      if (ld_issue_i) begin
        r_pl_valid <= 1'b1;
        r_pl_addr  <= ld_issue_waddr_i & AddrMask;
      end else if (lsu_valid_i) begin
        r_pl_valid <= 1'b0;
      end
    end
  end

  assign rf_we_o    = r_out.valid;
  assign rf_waddr_o = r_out.addr;
  assign rf_wdata_o = r_out.data;

  assign w_ra_a   = raddr_a_i & AddrMask;
  assign w_ra_b   = raddr_b_i & AddrMask;
  assign w_pl_hit = r_pl_valid &&
                    (((r_pl_addr == w_ra_a) && (w_ra_a != 5'd0)) ||
                     ((r_pl_addr == w_ra_b) && (w_ra_b != 5'd0)));

`ifdef IBEX_WB_FWD_EN
  wb_entry_t r_shd;

  // SHD covers the register file's internal sample stage after OUT retires.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_shd <= '0;
    else         r_shd <= r_out;
  end

  ibex_wb_fwd_match u_fwd_a (
    .i_buf  (r_buf),
    .i_out  (r_out),
    .i_shd  (r_shd),
    .i_raddr(w_ra_a),
    .o_valid(fwd_a_valid_o),
    .o_data (fwd_a_data_o)
  );

  ibex_wb_fwd_match u_fwd_b (
    .i_buf  (r_buf),
    .i_out  (r_out),
    .i_shd  (r_shd),
    .i_raddr(w_ra_b),
    .o_valid(fwd_b_valid_o),
    .o_data (fwd_b_data_o)
  );

  assign hazard_o = w_pl_hit;
`else
  assign fwd_a_valid_o = 1'b0;
  assign fwd_b_valid_o = 1'b0;
  assign fwd_a_data_o  = '0;
  assign fwd_b_data_o  = '0;
  // Without forwarding, decode must also wait out any in-flight write it reads.
  assign hazard_o = w_pl_hit ||
                    entry_hit(r_out, w_ra_a) || entry_hit(r_out, w_ra_b) ||
                    entry_hit(r_buf, w_ra_a) || entry_hit(r_buf, w_ra_b);
`endif

`ifndef SYNTHESIS
  a_one_load_outstanding : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (ld_issue_i && r_pl_valid) |-> lsu_valid_i);
`endif

endmodule

// File: tb/tb_ibex_wb_write_arbiter.sv
// Scoreboard bench: expected register-file writes (address, data, cycle) are queued
// by the stimulus and retired by per-DUT monitors; decode-side outputs checked inline.
module tb_ibex_wb_write_arbiter;
  import ibex_wb_pkg::*;

`ifdef IBEX_WB_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 0, lsu_valid = 0, ld_issue = 0, dummy = 0;
  logic [4:0]  ex_waddr = 0, lsu_waddr = 0, ld_waddr = 0, ra_a = 0, ra_b = 0;
  logic [31:0] ex_wdata = 0, lsu_wdata = 0;

  logic        d0_ready, d0_fa_v, d0_fb_v, d0_haz, d0_we;
  logic [31:0] d0_fa_d, d0_fb_d, d0_wdata;
  logic [4:0]  d0_waddr;
  logic        d1_ready, d1_fa_v, d1_fb_v, d1_haz, d1_we;
  logic [31:0] d1_fa_d, d1_fb_d, d1_wdata;
  logic [4:0]  d1_waddr;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  ibex_wb_write_arbiter dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(d0_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .ld_issue_i(ld_issue), .ld_issue_waddr_i(ld_waddr), .dummy_instr_i(dummy),
    .raddr_a_i(ra_a), .raddr_b_i(ra_b),
    .fwd_a_valid_o(d0_fa_v), .fwd_b_valid_o(d0_fb_v), .fwd_a_data_o(d0_fa_d), .fwd_b_data_o(d0_fb_d),
    .hazard_o(d0_haz), .rf_we_o(d0_we), .rf_waddr_o(d0_waddr), .rf_wdata_o(d0_wdata)
  );

  ibex_wb_write_arbiter #(.DummyInstructions(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(d1_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .ld_issue_i(ld_issue), .ld_issue_waddr_i(ld_waddr), .dummy_instr_i(dummy),
    .raddr_a_i(ra_a), .raddr_b_i(ra_b),
    .fwd_a_valid_o(d1_fa_v), .fwd_b_valid_o(d1_fb_v), .fwd_a_data_o(d1_fa_d), .fwd_b_data_o(d1_fb_d),
    .hazard_o(d1_haz), .rf_we_o(d1_we), .rf_waddr_o(d1_waddr), .rf_wdata_o(d1_wdata)
  );

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write becomes visible on rf_we_o in cycle 'when'.
  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int when, input bit both);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = when;
    q1.push_back(e);
    if (both) q0.push_back(e);
  endtask

  always @(negedge clk) begin
    if (d0_we) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL d0_unexpected_write: got x%0d=0x%0h, expected no write", d0_waddr, d0_wdata);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("d0_waddr", 64'(d0_waddr), 64'(e.addr));
        check("d0_wdata", 64'(d0_wdata), 64'(e.data));
        check("d0_wcycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (d1_we) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL d1_unexpected_write: got x%0d=0x%0h, expected no write", d1_waddr, d1_wdata);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_waddr", 64'(d1_waddr), 64'(e.addr));
        check("d1_wdata", 64'(d1_wdata), 64'(e.data));
        check("d1_wcycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(d0_we), 0);
    check({tag, "_waddr"}, 64'(d0_waddr), 0);
    check({tag, "_wdata"}, 64'(d0_wdata), 0);
    check({tag, "_ready"}, 64'(d0_ready), 1);
    check({tag, "_hazard"}, 64'(d0_haz), 0);
    check({tag, "_fa_v"},  64'(d0_fa_v), 0);
    check({tag, "_fb_v"},  64'(d0_fb_v), 0);
    check({tag, "_fa_d"},  64'(d0_fa_d), 0);
    check({tag, "_fb_d"},  64'(d0_fb_d), 0);
  endtask

  initial begin
    #2;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Lone EX write: one-cycle latency, ready stays high.
    tick();
    ex_valid = 1; ex_waddr = 5; ex_wdata = 32'h1234;
    expect_wr(5, 32'h1234, cyc + 1, 1);
    #1 check("t1_ready_pre", 64'(d0_ready), 1);
    tick();
    ex_valid = 0;
    check("t1_ready_post", 64'(d0_ready), 1);
    check("t1_we", 64'(d0_we), 1);

    // LSU and EX collide: LSU first, EX buffered one extra cycle.
    tick();
    lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'hAAAA;
    ex_valid  = 1; ex_waddr  = 4; ex_wdata  = 32'hBBBB;
    expect_wr(3, 32'hAAAA, cyc + 1, 1);
    expect_wr(4, 32'hBBBB, cyc + 2, 1);
    tick();
    lsu_valid = 0; ex_valid = 0;
    check("t2_ready_full", 64'(d0_ready), 0);
    tick();
    check("t2_ready_empty", 64'(d0_ready), 1);

    // FULL with a new LSU response: buffer holds, EX is stalled until drain.
    tick();
    lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h11;
    ex_valid  = 1; ex_waddr  = 4; ex_wdata  = 32'h22;
    expect_wr(3, 32'h11, cyc + 1, 1);
    tick();
    lsu_waddr = 10; lsu_wdata = 32'hCC;
    ex_waddr  = 11; ex_wdata  = 32'h33;
    expect_wr(10, 32'hCC, cyc + 1, 1);
    check("t3_ready_full1", 64'(d0_ready), 0);
    tick();
    lsu_valid = 0;
    expect_wr(4, 32'h22, cyc + 1, 1);
    check("t3_ready_full2", 64'(d0_ready), 0);
    tick();
    expect_wr(11, 32'h33, cyc + 1, 1);
    check("t3_ready_drained", 64'(d0_ready), 1);
    tick();
    ex_valid = 0;

    // Pending load hazard on port A.
    tick();
    ld_issue = 1; ld_waddr = 7;
    tick();
    ld_issue = 0; ra_a = 7;
    #1 check("t4_hazard_pend1", 64'(d0_haz), 1);
    tick();
    check("t4_hazard_pend2", 64'(d0_haz), 1);
    tick();
    lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h77;
    expect_wr(7, 32'h77, cyc + 1, 1);
    #1 check("t4_hazard_resp", 64'(d0_haz), 1);
    tick();
    lsu_valid = 0;
    check("t4_hazard_after", 64'(d0_haz), Fwd ? 0 : 1);
    tick();
    check("t4_hazard_clear", 64'(d0_haz), 0);
    ra_a = 0;

    // Forwarding on port B across the OUT and SHD window.
    tick();
    ex_valid = 1; ex_waddr = 9; ex_wdata = 32'h55;
    expect_wr(9, 32'h55, cyc + 1, 1);
    tick();
    ex_valid = 0; ra_b = 9;
    #1;
    check("t5_fb_v_out", 64'(d0_fb_v), Fwd ? 1 : 0);
    check("t5_fb_d_out", 64'(d0_fb_d), Fwd ? 64'h55 : 0);
    check("t5_haz_out", 64'(d0_haz), Fwd ? 0 : 1);
    tick();
    check("t5_fb_v_shd", 64'(d0_fb_v), Fwd ? 1 : 0);
    check("t5_fb_d_shd", 64'(d0_fb_d), Fwd ? 64'h55 : 0);
    check("t5_haz_shd", 64'(d0_haz), 0);
    tick();
    check("t5_fb_v_done", 64'(d0_fb_v), 0);
    check("t5_fb_d_done", 64'(d0_fb_d), 0);
    check("t5_fa_v_idle", 64'(d0_fa_v), 0);
    ra_b = 0;

    // x0 writes: dropped, unless tagged dummy on the DummyInstructions build.
    tick();
    ex_valid = 1; ex_waddr = 0; ex_wdata = 32'hFF; dummy = 1;
    expect_wr(0, 32'hFF, cyc + 1, 0);
    #1 check("t6_ready_x0", 64'(d0_ready), 1);
    tick();
    ex_valid = 0; dummy = 0;
    check("t6_d0_we_x0", 64'(d0_we), 0);
    check("t6_d1_we_x0", 64'(d1_we), 1);
    check("t6_d1_waddr_x0", 64'(d1_waddr), 0);
    tick();
    ex_valid = 1; ex_waddr = 0; ex_wdata = 32'hEE;
    tick();
    ex_valid = 0;
    check("t6_d0_we_plain", 64'(d0_we), 0);
    check("t6_d1_we_plain", 64'(d1_we), 0);

    // Reset while FULL with a pending load: buffered write is discarded.
    tick();
    lsu_valid = 1; lsu_waddr = 3; lsu_wdata = 32'h3333;
    ex_valid  = 1; ex_waddr  = 4; ex_wdata  = 32'h4444;
    ld_issue  = 1; ld_waddr  = 12;
    expect_wr(3, 32'h3333, cyc + 1, 1);
    tick();
    lsu_valid = 0; ex_valid = 0; ld_issue = 0; ra_a = 12;
    #1;
    check("t7_ready_full", 64'(d0_ready), 0);
    check("t7_hazard_pre", 64'(d0_haz), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t7_rst");
    tick();
    check("t7_we_held", 64'(d0_we), 0);
    rst_n = 1'b1;
    ra_a = 0;

    repeat (4) tick();
    check("d0_queue_empty", 64'(q0.size()), 0);
    check("d1_queue_empty", 64'(q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule

// File: doc/ibex_wb_write_arbiter.md
# ibex_wb_write_arbiter

Writeback-stage arbiter that sits directly upstream of the latch-based register file. It merges the execute-stage result stream and the load/store-unit response stream onto the file's single write port (`we`/`waddr`/`wdata`). It holds a one-entry skid buffer for colliding execute writes and tracks one outstanding load destination. It also supplies forwarding and hazard information to the decode stage for writes the register file cannot yet return on a read.

## Interface
Parameters:
- DataWidth, 32, data width of every write and forward path.
- RV32E, 0, when 1, address width is 4; bit 4 of every address input is ignored.
- DummyInstructions, 0, when 1, writes to x0 tagged by `dummy_instr_i` are passed through instead of dropped.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- ex_valid_i  in  1  execute result valid.
- ex_waddr_i  in  5  execute destination register.
- ex_wdata_i  in  DataWidth  execute result.
- ex_ready_o  out  1  execute result accepted this cycle when high together with ex_valid_i.
- lsu_valid_i  in  1  load response valid; cannot be back-pressured.
- lsu_waddr_i  in  5  load destination register.
- lsu_wdata_i  in  DataWidth  load data.
- ld_issue_i  in  1  load request issued this cycle.
- ld_issue_waddr_i  in  5  destination register of the issued load.
- dummy_instr_i  in  1  current write belongs to a dummy instruction.
- raddr_a_i, raddr_b_i  in  5  decode-stage read addresses.
- fwd_a_valid_o, fwd_b_valid_o  out  1  forward data must replace the register-file read.
- fwd_a_data_o, fwd_b_data_o  out  DataWidth  forward data.
- hazard_o  out  1  a read address matches the pending load destination; decode must stall.
- rf_we_o  out  1  register-file write enable (registered).
- rf_waddr_o  out  5  register-file write address (registered).
- rf_wdata_o  out  DataWidth  register-file write data (registered).

## Operation
- State:
  - output register OUT: valid, addr, data.
  - skid buffer BUF: full, addr, data.
  - shadow SHD: valid, addr, data. SHD holds the previous OUT contents while the register file's internal sample stage makes the write visible.
  - pending load PL: valid, addr.
- Buffer FSM states are EMPTY and FULL. `ex_ready_o = (state == EMPTY)`, driven combinationally from state only.
- OUT load priority each cycle:
  1. LSU response.
  2. BUF contents.
  3. Accepted EX write.
  4. Nothing; OUT.valid is cleared.
- EMPTY state:
  - LSU and EX accept in the same cycle: LSU goes to OUT, EX goes to BUF, next state FULL.
  - EX accept alone: EX goes to OUT.
- FULL state:
  - LSU valid: BUF holds.
  - No LSU: BUF drains to OUT, next state EMPTY.
  - No EX is accepted while FULL.
- x0 filtering:
  - A write with address 0 is dropped at the input: it is not loaded and `rf_we_o` stays low.
  - Exception: when DummyInstructions=1 and `dummy_instr_i` is high, the write passes through.
  - Dropped EX writes still handshake normally.
- Pending load tracking:
  - `ld_issue_i` sets PL to valid with `ld_issue_waddr_i`.
  - `lsu_valid_i` clears PL.
  - Issue and response in the same cycle: PL is set with the new address.
  - At most one load is outstanding. A simulation assertion fires on issue while PL is valid without a same-cycle response.
- `hazard_o` = PL.valid & (PL.addr == raddr_a_i | PL.addr == raddr_b_i), with the matching address nonzero.
- Forwarding, per read port:
  - Youngest match wins, in the order BUF, then OUT, then SHD.
  - Address 0 never forwards.
  - Comparisons use the ADDR_WIDTH low bits.
- `rf_we_o = OUT.valid`; `rf_waddr_o`/`rf_wdata_o` = OUT.addr/OUT.data.

## Timing
- Latency from accepted input to `rf_we_o` is one cycle. A buffered EX write takes two cycles or more.
- The register file returns the new value two cycles after `rf_we_o`. Forwarding covers that window through OUT and SHD.
- Reset values:
  - All valid, full, and pending flags are 0.
  - State is EMPTY.
  - `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0.
  - `ex_ready_o`=1, `hazard_o`=0, `fwd_*_valid_o`=0, `fwd_*_data_o`=0.
- Reset mid-operation discards OUT, BUF, SHD and PL contents; no partial write is issued.
- Forward and hazard outputs are combinational from the current state and read addresses.

## Configuration
- `IBEX_WB_FWD_EN`:
  - Defined: the forwarding muxes and the SHD register are built.
  - Undefined: `fwd_*_valid_o`=0 and `fwd_*_data_o`=0, SHD is removed, and `hazard_o` additionally asserts on any address match with OUT or BUF.

## Structure
- Shared package `ibex_wb_pkg`:
  - `wb_entry_t` {valid, addr[4:0], data} typedef.
  - `buf_state_e` {EMPTY, FULL}.
  - ADDR_WIDTH helper function.
- Sub-module `ibex_wb_fwd_match`: a one-port priority comparator over BUF/OUT/SHD, instantiated once per read port.

## Test plan
- EX write x5=0x1234 alone -> next cycle `rf_we_o`=1, `rf_waddr_o`=5, `rf_wdata_o`=0x1234; `ex_ready_o` stays 1.
- LSU x3=0xAAAA together with EX x4=0xBBBB -> cycle+1 writes x3; `ex_ready_o`=0 during cycle+1; cycle+2 writes x4.
- `ld_issue_i` with x7, then raddr_a_i=7 -> `hazard_o`=1 until the `lsu_valid_i` cycle; `hazard_o`=0 on the cycle after.
- EX x9=0x55, then raddr_b_i=9 for three cycles -> `fwd_b_valid_o`=1 with 0x55 on the cycles covering OUT and SHD, then 0.
- EX x0=0xFF with DummyInstructions=0 -> `rf_we_o` stays 0. Same stimulus with DummyInstructions=1 and `dummy_instr_i`=1 -> `rf_we_o`=1 with `rf_waddr_o`=0.
- Assert rst_ni low while state is FULL -> all outputs return to reset values immediately; the buffered write is never issued.
